// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with standard or first-word-fall-through read mode
module fifo_param #(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_en,
  input  logic [D_WIDTH-1:0]    buf_in,
  input  logic                  rd_en,
  output logic [D_WIDTH-1:0]    buf_out,
  output logic                  out_valid,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_counter,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [D_WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d, mem_cnt;
  logic [D_WIDTH-1:0]    buf_out_q;
  logic                  out_valid_q, out_valid_d, overflow_q, underflow_q;
  logic                  rd_acc, wr_acc, load;
  assign buf_empty    = (FWFT != 0) ? !out_valid_q : (count_q == '0);
  assign buf_full     = (count_q == DEPTH_C);
  assign rd_acc       = rd_en & !buf_empty;
  assign wr_acc       = wr_en & (!buf_full | rd_acc);
  // In FWFT mode the head word lives in buf_out, so the array holds count minus that word.
  assign mem_cnt      = count_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign load         = (FWFT != 0) ? ((mem_cnt != '0) & (!out_valid_q | rd_acc)) : rd_acc;
  assign count_d      = count_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
  assign out_valid_d  = (FWFT != 0) ? (load | (out_valid_q & !rd_acc)) : rd_acc;
  assign buf_out      = buf_out_q;
  assign out_valid    = out_valid_q;
  assign fifo_counter = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !clr_i) mem[wr_ptr_q] <= buf_in;
  end
  // Pointers, occupancy, output register and sticky error flags; flush leaves buf_out untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      buf_out_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(wr_acc);
      rd_ptr_q    <= rd_ptr_q + ADDR_WIDTH'(load);
      count_q     <= count_d;
      if (load) buf_out_q <= mem[rd_ptr_q];
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_q | (wr_en & !wr_acc);
      underflow_q <= underflow_q | (rd_en & buf_empty);
    end
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed checks of fifo_param in standard and FWFT modes
module tb_fifo_param;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] buf_in = '0;
  logic [31:0] s_out, f_out;
  logic        s_ov, s_emp, s_full, s_ae, s_af, s_ovf, s_unf;
  logic        f_ov, f_emp, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [4:0]  s_cnt, f_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fifo_param #(.FWFT(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
    .buf_out(s_out), .out_valid(s_ov), .buf_empty(s_emp), .buf_full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .fifo_counter(s_cnt),
    .overflow(s_ovf), .underflow(s_unf));
  fifo_param #(.FWFT(1)) dut_f (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
    .buf_out(f_out), .out_valid(f_ov), .buf_empty(f_emp), .buf_full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .fifo_counter(f_cnt),
    .overflow(f_ovf), .underflow(f_unf));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst_cnt", s_cnt, 0);
    chk("rst_emp", s_emp, 1);
    chk("rst_full", s_full, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    chk("rst_ov", s_ov, 0);
    chk("rst_out", s_out, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_unf", s_unf, 0);
    chk("rst_f_emp", f_emp, 1);
    rst = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      buf_in = 32'(i);
      cyc();
      chk("fill_cnt", s_cnt, 64'(i + 1));
      chk("fill_af", s_af, 64'(i + 1 >= 14));
      chk("fill_ae", s_ae, 64'(i + 1 <= 2));
    end
    chk("full", s_full, 1);
    chk("full_emp", s_emp, 0);
    rd_en = 1'b1;
    buf_in = 32'hAA;
    cyc();
    chk("pass_cnt", s_cnt, 16);
    chk("pass_ovf", s_ovf, 0);
    chk("pass_out", s_out, 0);
    chk("pass_ov", s_ov, 1);
    rd_en = 1'b0;
    buf_in = 32'h99;
    cyc();
    chk("ovf_set", s_ovf, 1);
    chk("ovf_cnt", s_cnt, 16);
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("drain_data", s_out, (i < 15) ? 64'(i + 1) : 64'hAA);
      chk("drain_ov", s_ov, 1);
    end
    chk("drain_emp", s_emp, 1);
    chk("drain_unf0", s_unf, 0);
    cyc();
    chk("unf_set", s_unf, 1);
    chk("unf_ov", s_ov, 0);
    chk("unf_hold", s_out, 32'hAA);
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      buf_in = 32'h200 + 32'(i);
      cyc();
    end
    chk("c9_cnt", s_cnt, 9);
    chk("c9_ovf", s_ovf, 1);
    clr = 1'b1;
    rd_en = 1'b1;
    cyc();
    clr = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("clr_cnt", s_cnt, 0);
    chk("clr_emp", s_emp, 1);
    chk("clr_ovf", s_ovf, 0);
    chk("clr_unf", s_unf, 0);
    chk("clr_out", s_out, 32'hAA);
    chk("clr_ov", s_ov, 0);
    wr_en = 1'b1;
    buf_in = 32'h11;
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("std_lat_out", s_out, 32'h11);
    chk("std_lat_ov", s_ov, 1);
    cyc();
    chk("std_ov_drop", s_ov, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("f_clr_emp", f_emp, 1);
    wr_en = 1'b1;
    buf_in = 32'h55;
    cyc();
    wr_en = 1'b0;
    chk("f_lat_k_ov", f_ov, 0);
    chk("f_lat_k_cnt", f_cnt, 1);
    cyc();
    chk("f_lat_k1_ov", f_ov, 1);
    chk("f_lat_k1_out", f_out, 32'h55);
    chk("f_lat_k1_emp", f_emp, 0);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("f_pop_ov", f_ov, 0);
    chk("f_pop_cnt", f_cnt, 0);
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      buf_in = 32'h60 + 32'(i);
      cyc();
    end
    wr_en = 1'b0;
    cyc();
    chk("f_str_head", f_out, 32'h60);
    chk("f_str_cnt", f_cnt, 8);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("f_str_ov", f_ov, 64'(i < 7));
      if (i < 7) chk("f_str_data", f_out, 64'h61 + 64'(i));
    end
    rd_en = 1'b0;
    chk("f_str_cnt0", f_cnt, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      buf_in = 32'h100 + 32'(i);
      cyc();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      buf_in = 32'h103 + 32'(i);
      cyc();
      chk("wrap_s", s_out, 64'h100 + 64'(i));
      chk("wrap_f", f_out, 64'h101 + 64'(i));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wrap_cnt", s_cnt, 3);
    chk("wrap_f_cnt", f_cnt, 3);
    chk("wrap_ovf", s_ovf, 0);
    chk("wrap_unf", s_unf, 0);
    chk("wrap_f_flags", {f_ovf, f_unf}, 0);
    wr_en = 1'b1;
    buf_in = 32'h300;
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", s_cnt, 0);
    chk("arst_out", s_out, 0);
    chk("arst_emp", s_emp, 1);
    chk("arst_f_ov", f_ov, 0);
    chk("arst_f_out", f_out, 0);
    wr_en = 1'b0;
    cyc();
    #2 rst = 1'b0;
    wr_en = 1'b1;
    buf_in = 32'h77;
    cyc();
    wr_en = 1'b0;
    chk("post_rst_cnt", s_cnt, 1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("post_rst_out", s_out, 32'h77);
    chk("post_rst_unf", s_unf, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the successor to the fixed single-mode buffer in the stat datapath. It supports power-of-two depth and configurable almost-full/almost-empty thresholds. It offers a standard (registered-read) mode or a first-word-fall-through (FWFT) mode, and allows a write to a full FIFO when a read is accepted in the same cycle. It also provides a synchronous flush and sticky overflow/underflow error flags. It buffers samples between the statistics producers and consumers on a single clock.

## Interface
- D_WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH words.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- clr_i  in  1  synchronous flush.
- wr_en  in  1  write request.
- buf_in  in  D_WIDTH  write data.
- rd_en  in  1  read request (FWFT: pop/acknowledge of buf_out).
- buf_out  out  D_WIDTH  read data.
- out_valid  out  1  buf_out holds a valid word.
- buf_empty, buf_full  out  1 each  empty/full status.
- almost_empty, almost_full  out  1 each  threshold status.
- fifo_counter  out  ADDR_WIDTH+1  words held, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Storage: DEPTH-entry array, ADDR_WIDTH-bit rd/wr pointers wrapping modulo DEPTH. fifo_counter is a separate (ADDR_WIDTH+1)-bit counter.
- rd_acc = rd_en & !buf_empty.
- wr_acc = wr_en & (!buf_full | rd_acc). A write to a full FIFO is accepted only if a read is accepted in the same cycle.
- Counter: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Standard mode (FWFT=0):
  - buf_empty = (count==0); buf_full = (count==DEPTH).
  - On rd_acc, buf_out <= mem[rd_ptr] and out_valid <= 1. Otherwise out_valid <= 0 and buf_out holds.
- FWFT mode (FWFT=1):
  - The head word is pre-fetched into the buf_out register; out_valid = head present; buf_empty = !out_valid.
  - fifo_counter includes the head word.
  - rd_acc pops the head. The next word (if any) is loaded in the same edge, so back-to-back reads stream without bubbles.
- Status flags are combinational from registered state: almost_full = (count >= AF_LEVEL), almost_empty = (count <= AE_LEVEL).
- Error flags:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & buf_empty.
  - Both are sticky until clr_i or rst_i.
- clr_i has priority over wr_en/rd_en. In the same cycle it:
  - zeroes the pointers, count, out_valid, overflow and underflow;
  - ignores any requests in that cycle and sets no error flag;
  - leaves buf_out holding its value.
- Reset: fifo_counter=0, pointers=0, buf_out=0, out_valid=0, overflow=0, underflow=0. Hence buf_empty=1, buf_full=0, almost_empty=1, almost_full=0.
- Memory contents are not reset.

## Timing
- Write sampled at edge k: count and flags update after edge k.
- Standard mode:
  - Read sampled at edge k: buf_out/out_valid valid after edge k (1-cycle latency).
  - A write at edge k to an empty FIFO may be read at edge k+1.
- FWFT mode:
  - A write at edge k to an empty FIFO makes out_valid=1 after edge k+1 (write-to-visible latency 2 edges). The word must not appear before edge k+1.
  - Pop at edge k with a following word stored: out_valid stays 1 and buf_out updates after edge k.
- Simultaneous wr_acc & rd_acc: count unchanged; both pointers advance.
  - Full: the write succeeds and no overflow is flagged.
  - Empty: the read is refused, the write proceeds, and underflow is set if rd_en was high.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0. Data order is preserved across the wrap.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first write is sampled on the first rising edge after rst_i deasserts.

## Test plan
- Fill/drain, FWFT=0, ADDR_WIDTH=4: write 0..15 → buf_full=1, count=16, almost_full from count 14. A 17th write sets overflow=1 and count stays 16. Read 16 → data 0..15 in order, buf_empty=1. A 17th read sets underflow=1.
- Full pass-through: at count=16, assert wr_en=rd_en with buf_in=0xAA → count stays 16, overflow=0. 0xAA is read out as the 16th word after the remaining 15.
- FWFT latency: write 0x55 at edge k into empty → out_valid=0 after k, out_valid=1 with buf_out=0x55 after k+1. Stream 8 words with rd_en held high → one word per cycle, no bubbles.
- Wrap: 40 cycles of interleaved write/read at count ~3 → output sequence equals input sequence, no flags set.
- clr_i: with count=9 and overflow=1, assert clr_i together with wr_en and rd_en → count=0, buf_empty=1, overflow=0, underflow=0, buf_out unchanged.
- Async reset: assert rst_i between clock edges mid-stream → all outputs take reset values before the next edge. After deassertion, the first write is accepted normally.
